// File: rtl/irq_controller_pkg.sv
// Shared definitions for the interrupt controller: register byte offsets,
// controller state encoding, the "no source" id and a one-hot helper.
package irq_controller_pkg;

  // Register byte offsets inside the block (decoded on word boundaries)
  localparam logic [5:0] IRQ_PENDING  = 6'h00;
  localparam logic [5:0] IRQ_MASK     = 6'h04;
  localparam logic [5:0] IRQ_CLEAR    = 6'h08;
  localparam logic [5:0] IRQ_EDGE_SEL = 6'h0C;
  localparam logic [5:0] IRQ_ACTIVE   = 6'h10;
  localparam logic [5:0] IRQ_EOI      = 6'h14;
  localparam logic [5:0] IRQ_CNT_BASE = 6'h20;

  // Id reported when nothing is requested or in service
  localparam logic [2:0] NONE_ID = 3'd7;

  // Request/acknowledge/end-of-interrupt sequence
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  // One-hot of a source id onto the 6-bit CPU interrupt vector; ids 6/7 give 0
  function automatic logic [5:0] id_onehot(input logic [2:0] id);
    logic [5:0] oh;
    oh = 6'b000000;
    case (id)
      3'd0:    oh = 6'b000001;
      3'd1:    oh = 6'b000010;
      3'd2:    oh = 6'b000100;
      3'd3:    oh = 6'b001000;
      3'd4:    oh = 6'b010000;
      3'd5:    oh = 6'b100000;
      default: oh = 6'b000000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/irq_controller_prio_enc.sv
// Fixed-priority encoder: reports the lowest-index set request bit.
// Index 0 has the highest priority; id is NONE_ID when nothing is set.
module irq_prio_enc
  import irq_controller_pkg::*;
#(
  parameter int NUM_SRC = 6
) (
  input  logic [NUM_SRC-1:0] req_i,
  output logic               valid_o,
  output logic [2:0]         id_o
);

  logic       found_s;
  logic [2:0] id_s;

  // Scan upward and keep the first hit so lower indices win
  always_comb begin
    found_s = 1'b0;
    id_s    = NONE_ID;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (req_i[i] && !found_s) begin
        found_s = 1'b1;
        id_s    = 3'(i);
      end else begin
        found_s = found_s;
        id_s    = id_s;
      end
    end
  end

  assign valid_o = found_s;
  assign id_o    = id_s;

endmodule

// File: rtl/irq_controller.sv
// Programmable interrupt controller between peripheral IRQ lines and the
// CPU's 6-bit HWInt input. Latches level/edge requests, masks them, picks
// the highest-priority one and runs a request/ack/EOI handshake so the CPU
// sees one interrupt at a time.
// Optional build macro IRQ_STAT_EN adds per-source event counters at byte
// offsets 0x20.. and widens the register decode to addr[5:2].
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int NUM_SRC = 6,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        addr,
  input  logic               we,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               int_ack,
  output logic [5:0]         hw_int,
  output logic [2:0]         active_id
);

  // Architectural state
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] edge_sel_q, edge_sel_d;
  logic [NUM_SRC-1:0] prev_irq_q;
  irq_state_e         state_q, state_d;
  logic [2:0]         id_q, id_d;
  logic [5:0]         hw_int_q, hw_int_d;
  logic [2:0]         active_id_q, active_id_d;

  // Decode and datapath helpers
  logic [3:0]         word_s;
  logic               wr_mask_s, wr_clear_s, wr_edge_s, wr_eoi_s;
  logic [NUM_SRC-1:0] eligible_s;
  logic               sel_valid_s;
  logic [2:0]         sel_id_s;
  logic [5:0]         sel_oh_s;
  logic [5:0]         cur_oh_s;
  logic               cur_elig_s;
  logic               ack_take_s;
  logic [NUM_SRC-1:0] set_s, clr_s;
  logic [31:0]        rdata_s;
  logic               unused_s;

  // Word select; without counters the upper offsets alias the 3-bit decode
  always_comb begin
`ifdef IRQ_STAT_EN
    word_s = addr[5:2];
`else
    word_s = {1'b0, addr[4:2]};
`endif
    wr_mask_s  = we && (word_s == IRQ_MASK[5:2]);
    wr_clear_s = we && (word_s == IRQ_CLEAR[5:2]);
    wr_edge_s  = we && (word_s == IRQ_EDGE_SEL[5:2]);
    wr_eoi_s   = we && (word_s == IRQ_EOI[5:2]);
  end

  assign eligible_s = pending_q & mask_q;

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_prio_enc (
    .req_i   (eligible_s),
    .valid_o (sel_valid_s),
    .id_o    (sel_id_s)
  );

  assign sel_oh_s   = id_onehot(sel_id_s);
  assign cur_oh_s   = id_onehot(id_q);
  assign cur_elig_s = |(cur_oh_s[NUM_SRC-1:0] & eligible_s);

  // Handshake FSM: next state plus registered hw_int/active_id values
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    hw_int_d    = hw_int_q;
    active_id_d = active_id_q;
    ack_take_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_valid_s) begin
          state_d     = REQ;
          id_d        = sel_id_s;
          hw_int_d    = sel_oh_s;
          active_id_d = sel_id_s;
        end else begin
          hw_int_d    = 6'b000000;
          active_id_d = NONE_ID;
        end
      end
      REQ: begin
        // Latched id is kept even if a higher-priority source shows up
        if (int_ack) begin
          state_d     = SERVICE;
          hw_int_d    = 6'b000000;
          active_id_d = id_q;
          ack_take_s  = 1'b1;
        end else if (!cur_elig_s) begin
          state_d     = IDLE;
          hw_int_d    = 6'b000000;
          active_id_d = NONE_ID;
        end else begin
          hw_int_d    = cur_oh_s;
          active_id_d = id_q;
        end
      end
      SERVICE: begin
        hw_int_d = 6'b000000;
        if (wr_eoi_s) begin
          state_d     = IDLE;
          active_id_d = NONE_ID;
        end else begin
          active_id_d = id_q;
        end
      end
      default: begin
        state_d     = IDLE;
        id_d        = NONE_ID;
        hw_int_d    = 6'b000000;
        active_id_d = NONE_ID;
      end
    endcase
  end

  // Pending/mask/edge-select next values; a set in the same cycle beats a clear
  always_comb begin
    set_s     = irq_in & ~(edge_sel_q & prev_irq_q);
    clr_s     = ({NUM_SRC{wr_clear_s}} & wdata[NUM_SRC-1:0])
              | ({NUM_SRC{ack_take_s}} & cur_oh_s[NUM_SRC-1:0]);
    pending_d = (pending_q & ~clr_s) | set_s;
    if (wr_mask_s) begin
      mask_d = wdata[NUM_SRC-1:0];
    end else begin
      mask_d = mask_q;
    end
    if (wr_edge_s) begin
      edge_sel_d = wdata[NUM_SRC-1:0];
    end else begin
      edge_sel_d = edge_sel_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending_q   <= {NUM_SRC{1'b0}};
      mask_q      <= {NUM_SRC{1'b0}};
      edge_sel_q  <= {NUM_SRC{1'b0}};
      prev_irq_q  <= {NUM_SRC{1'b0}};
      state_q     <= IDLE;
      id_q        <= NONE_ID;
      hw_int_q    <= 6'b000000;
      active_id_q <= NONE_ID;
    end else begin
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      edge_sel_q  <= edge_sel_d;
      prev_irq_q  <= irq_in;
      state_q     <= state_d;
      id_q        <= id_d;
      hw_int_q    <= hw_int_d;
      active_id_q <= active_id_d;
    end
  end

`ifdef IRQ_STAT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0]   cnt_q [NUM_SRC];
  logic [NUM_SRC-1:0] cnt_wr_s;
  logic [NUM_SRC-1:0] cnt_inc_s;

  // Counter write strobes and pending 0->1 events
  always_comb begin
    cnt_inc_s = pending_d & ~pending_q;
    cnt_wr_s  = {NUM_SRC{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      if (we && (word_s == (IRQ_CNT_BASE[5:2] + 4'(i)))) begin
        cnt_wr_s[i] = 1'b1;
      end else begin
        cnt_wr_s[i] = 1'b0;
      end
    end
  end

  // Saturating event counters; a bus write zeroes the addressed counter
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!reset) begin
        cnt_q[i] <= {CNT_W{1'b0}};
      end else if (cnt_wr_s[i]) begin
        cnt_q[i] <= {CNT_W{1'b0}};
      end else if (cnt_inc_s[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_q[i] <= cnt_q[i] + CNT_ONE;
      end else begin
        cnt_q[i] <= cnt_q[i];
      end
    end
  end
`endif

  // Combinational register read mux; unmapped and write-only words read 0
  always_comb begin
    rdata_s = {32{1'b0}};
    case (word_s)
      IRQ_PENDING[5:2]:  rdata_s[NUM_SRC-1:0] = pending_q;
      IRQ_MASK[5:2]:     rdata_s[NUM_SRC-1:0] = mask_q;
      IRQ_EDGE_SEL[5:2]: rdata_s[NUM_SRC-1:0] = edge_sel_q;
      IRQ_ACTIVE[5:2]:   rdata_s[2:0]         = active_id_q;
      default: begin
`ifdef IRQ_STAT_EN
        for (int i = 0; i < NUM_SRC; i++) begin
          if (word_s == (IRQ_CNT_BASE[5:2] + 4'(i))) begin
            rdata_s[CNT_W-1:0] = cnt_q[i];
          end else begin
            rdata_s = rdata_s;
          end
        end
`else
        rdata_s = {32{1'b0}};
`endif
      end
    endcase
  end

  assign rdata     = rdata_s;
  assign hw_int    = hw_int_q;
  assign active_id = active_id_q;

  // Bus bits outside the decode and write data above the source count
  assign unused_s = ^{addr[31:5], addr[1:0], wdata, (CNT_W > 0)};

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed steps followed by a
// randomized phase, all checked against a behavioural model that tracks
// "which source is currently raised / being serviced" as plain integers.
module tb_irq_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [5:0]  irq_in;
  logic        int_ack;
  logic [5:0]  hw_int;
  logic [2:0]  active_id;

  int n_cmp = 0;
  int n_bad = 0;
  bit rd_chk = 1'b1;

  // Behavioural model state
  bit [5:0] m_pend, m_mask, m_edge, m_prev;
  int       m_cur;      // source raised or in service, -1 when none
  bit       m_acked;    // CPU has taken m_cur

  always #5 clk = ~clk;

  irq_controller #(.NUM_SRC(6), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .we        (we),
    .wdata     (wdata),
    .rdata     (rdata),
    .irq_in    (irq_in),
    .int_ack   (int_ack),
    .hw_int    (hw_int),
    .active_id (active_id)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_hw();
    return (m_cur >= 0 && !m_acked) ? (32'd1 << m_cur) : 32'd0;
  endfunction

  function automatic logic [31:0] m_act();
    return (m_cur < 0) ? 32'd7 : 32'(m_cur);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (a[4:2])
      3'd0:    return {26'd0, m_pend};
      3'd1:    return {26'd0, m_mask};
      3'd3:    return {26'd0, m_edge};
      3'd4:    return m_act();
      default: return 32'd0;
    endcase
  endfunction

  // Advance the model by one clock using the inputs currently applied
  task automatic model_step();
    bit [5:0] elig, clr, set;
    int       w;
    if (!reset) begin
      m_pend = 6'd0; m_mask = 6'd0; m_edge = 6'd0; m_prev = 6'd0;
      m_cur = -1; m_acked = 1'b0;
    end else begin
      elig = m_pend & m_mask;
      w    = int'(addr[4:2]);
      clr  = 6'd0;
      if (m_cur < 0) begin
        for (int i = 0; i < 6; i++) begin
          if (elig[i]) begin
            m_cur = i; m_acked = 1'b0;
            break;
          end
        end
      end else if (!m_acked) begin
        if (int_ack) begin
          m_acked = 1'b1;
          clr[m_cur] = 1'b1;
        end else if (!elig[m_cur]) begin
          m_cur = -1;
        end
      end else if (we && w == 5) begin
        m_cur = -1; m_acked = 1'b0;
      end
      if (we && w == 2) clr = clr | wdata[5:0];
      set    = irq_in & ~(m_edge & m_prev);
      m_pend = (m_pend & ~clr) | set;
      if (we && w == 1) m_mask = wdata[5:0];
      if (we && w == 3) m_edge = wdata[5:0];
      m_prev = irq_in;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("hw_int", {26'd0, hw_int}, m_hw());
    chk("active_id", {29'd0, active_id}, m_act());
    if (rd_chk) chk("rdata", rdata, m_read(addr));
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick();
    we = 1'b0; addr = 32'h0; wdata = 32'h0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [31:0] r;
    reset = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0;
    irq_in = 6'd0; int_ack = 1'b0;
    idle(2);
    reset = 1'b1;

    // Reset readback of every word
    for (int a = 0; a < 8; a++) begin
      addr = 32'(a * 4);
      tick();
    end
    addr = 32'h0;
    chk("rst_active", {29'd0, active_id}, 32'd7);

    // 1: level source 1, latency pending then request
    wr(32'h04, 32'h03);
    wr(32'h0C, 32'h00);
    idle(2);
    irq_in = 6'b000010;
    tick();
    chk("t1_pend", rdata, 32'h2);
    chk("t1_hw0", {26'd0, hw_int}, 32'h0);
    tick();
    chk("t1_hw", {26'd0, hw_int}, 32'h2);
    chk("t1_act", {29'd0, active_id}, 32'd1);

    // 2: higher priority does not replace latched id; ack; EOI
    irq_in = 6'b000011;
    tick();
    chk("t2_hold", {26'd0, hw_int}, 32'h2);
    irq_in = 6'b000001;
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    chk("t2_ack_hw", {26'd0, hw_int}, 32'h0);
    chk("t2_ack_pend", rdata, 32'h1);
    wr(32'h14, 32'h0);
    tick();
    chk("t2_next_hw", {26'd0, hw_int}, 32'h1);
    chk("t2_next_act", {29'd0, active_id}, 32'd0);
    irq_in = 6'd0;
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    wr(32'h14, 32'h0);
    wr(32'h08, 32'h3F);
    tick();

    // 3: edge source 2 held high
    wr(32'h0C, 32'h04);
    wr(32'h04, 32'h04);
    irq_in = 6'b000100;
    idle(5);
    chk("t3_hw", {26'd0, hw_int}, 32'h4);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("t3_pend_clr", rdata, 32'h0);
    wr(32'h08, 32'h04);
    wr(32'h14, 32'h0);
    idle(3);
    chk("t3_no_rereq", {26'd0, hw_int}, 32'h0);
    irq_in = 6'd0; tick();
    irq_in = 6'b000100; tick(); tick();
    chk("t3_rereq", {26'd0, hw_int}, 32'h4);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    wr(32'h14, 32'h0);
    irq_in = 6'd0;
    tick();

    // 4: mask removed while requesting
    wr(32'h0C, 32'h00);
    wr(32'h04, 32'h02);
    irq_in = 6'b000010;
    idle(2);
    chk("t4_req", {26'd0, hw_int}, 32'h2);
    wr(32'h04, 32'h00);
    tick();
    chk("t4_drop_hw", {26'd0, hw_int}, 32'h0);
    chk("t4_drop_act", {29'd0, active_id}, 32'd7);
    irq_in = 6'd0;
    wr(32'h08, 32'h3F);

    // 5: ignored ack/EOI, then reset during service
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("t5_ack_idle", {29'd0, active_id}, 32'd7);
    wr(32'h04, 32'h01);
    irq_in = 6'b000001;
    idle(2);
    wr(32'h14, 32'h0);
    chk("t5_eoi_req", {26'd0, hw_int}, 32'h1);
    int_ack = 1'b1; tick(); int_ack = 1'b0;
    chk("t5_svc_act", {29'd0, active_id}, 32'd0);
    reset = 1'b0; tick(); reset = 1'b1;
    irq_in = 6'd0;
    chk("t5_rst_hw", {26'd0, hw_int}, 32'h0);
    chk("t5_rst_act", {29'd0, active_id}, 32'd7);
    addr = 32'h04; tick();
    chk("t5_rst_mask", rdata, 32'h0);
    addr = 32'h0;

`ifdef IRQ_STAT_EN
    // 6: saturating event counter of source 0
    wr(32'h0C, 32'h01);
    wr(32'h04, 32'h00);
    for (int i = 0; i < 300; i++) begin
      irq_in = 6'b000001; tick();
      irq_in = 6'd0;
      wr(32'h08, 32'h01);
    end
    rd_chk = 1'b0;
    addr = 32'h20; tick();
    chk("t6_sat", rdata, 32'hFF);
    wr(32'h20, 32'h0);
    addr = 32'h20; tick();
    chk("t6_zero", rdata, 32'h0);
    addr = 32'h0;
    rd_chk = 1'b1;
    wr(32'h0C, 32'h00);
`endif

    // Randomized phase against the model
    for (int c = 0; c < 1500; c++) begin
      r = $urandom;
      reset   = (r[7:0] != 8'd0);
      if (r[9:8] == 2'd0) irq_in = r[15:10];
      int_ack = (r[17:16] == 2'd0);
      we      = (r[19:18] == 2'd0);
      r = $urandom;
      addr  = {r[31:6], 1'b0, r[4:2], r[1:0]};
      wdata = $urandom;
      tick();
    end
    we = 1'b0; int_ack = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Programmable interrupt controller between the peripheral interrupt lines (Timer1 IRQ, Timer2 IRQ, external interrupt) and the CPU's 6-bit HWInt input.
- Memory-mapped behind the bridge like the timers.
- Latches interrupt requests as level- or edge-sensitive, masks them, and selects one by fixed priority.
- Runs a request/acknowledge/end-of-interrupt sequence so the CPU sees exactly one well-defined interrupt at a time.

Parameters:
- NUM_SRC, 6, number of interrupt sources; legal range 1..6; source i drives hw_int[i].
- CNT_W, 8, width of the per-source event counters; used only with IRQ_STAT_EN.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; asserted when reset==0, sampled on the rising edge of clk.
- addr  input  32  bus byte address; only addr[4:2] decoded, block selected by the bridge.
- we  input  1  bus write enable, valid with addr and wdata for one cycle.
- wdata  input  32  bus write data.
- rdata  output  32  bus read data; combinational from addr.
- irq_in  input  NUM_SRC  raw interrupt lines; index 0 is highest priority.
- int_ack  input  1  one-cycle pulse from the CPU when it enters the exception handler.
- hw_int  output  6  registered one-hot request to the CPU; bits at NUM_SRC and above are tied to 0.
- active_id  output  3  id of the source currently requested or in service; 7 when none.

Behaviour:
- Register map (offset from addr[4:2]):
  - 0x00 PENDING: read-only.
  - 0x04 MASK: read/write; 1 = enabled.
  - 0x08 CLEAR: write-1-to-clear PENDING.
  - 0x0C EDGE_SEL: read/write; 1 = edge, 0 = level.
  - 0x10 ACTIVE: read-only; returns {29'b0, active_id}.
  - 0x14 EOI: write-only; any write counts as EOI.
  - Other offsets: read 0, write ignored. Unused upper bits read 0.
- Reset values: PENDING=0, MASK=0, EDGE_SEL=0, prev_irq=0, state=IDLE, hw_int=0, active_id=7.
- Pending set rules:
  - Level source: set every cycle irq_in[i]==1.
  - Edge source: set when irq_in[i]==1 and prev_irq[i]==0.
  - prev_irq is a register copy of irq_in.
- Pending clear: by a CLEAR write bit, or automatically for the acknowledged source on int_ack. If set and clear occur in the same cycle, set wins.
- Eligible vector = PENDING & MASK. Selection is the lowest-index eligible bit.
- State machine:
  - IDLE: when eligible != 0, latch the selected id, go to REQ, and register hw_int = one-hot(id).
  - REQ: hw_int stays held. On int_ack, go to SERVICE, set hw_int=0, clear PENDING[id]. If eligible[id] drops (CLEAR or MASK write) before int_ack, go back to IDLE with hw_int=0 and active_id=7. A higher-priority source becoming eligible does not replace the latched id.
  - SERVICE: hw_int=0 and active_id holds the id. An EOI write returns to IDLE with active_id=7. No nesting.
- Ignored events: int_ack outside REQ; EOI outside SERVICE.
- Latency: irq_in rises at edge n → PENDING set at edge n+1 → hw_int set at edge n+2. After EOI at edge k, the next request can appear at edge k+1.
- A level source still high after ack re-pends on the next cycle.
- A write takes effect at the clock edge and is visible to the selection logic in the following cycle.
- Reset mid-operation returns everything to the reset values in one cycle.

Optional Feature:
- Macro: IRQ_STAT_EN.
- Defined:
  - Each source has a CNT_W-bit counter that increments whenever its pending bit goes from 0 to 1, saturating at all-ones.
  - Read at 0x18 + 4*i for i<NUM_SRC is not decodable with addr[4:2] alone; with the feature, addr[5:2] is decoded and counters sit at offsets 0x20..0x34.
  - A write of any value to a counter offset zeroes that counter. Counters reset to 0.
- Undefined: no counters, only addr[4:2] is decoded, and 0x20..0x34 alias per the 3-bit decode.

Decomposition:
- Shared package holds:
  - Register offset constants: IRQ_PENDING, IRQ_MASK, IRQ_CLEAR, IRQ_EDGE_SEL, IRQ_ACTIVE, IRQ_EOI, IRQ_CNT_BASE.
  - State encoding: IDLE=2'd0, REQ=2'd1, SERVICE=2'd2.
  - The NONE_ID=3'd7 constant.
- Sub-module irq_prio_enc: a combinational NUM_SRC-bit priority encoder producing {valid, id}. Everything else stays in irq_controller.

Test Plan:
1. Reset then MASK=0x03, EDGE_SEL=0. Raise irq_in=6'b000010 at edge 10 → PENDING=0x02 after edge 11, hw_int=6'b000010 after edge 12, active_id=1.
2. In REQ for id 1, raise irq_in[0] → hw_int stays 6'b000010. Pulse int_ack → hw_int=0, PENDING[1] cleared. Write EOI → after one cycle hw_int=6'b000001, active_id=0.
3. EDGE_SEL=0x04, MASK=0x04. Hold irq_in[2] high 5 cycles → PENDING[2] set once. After ack and CLEAR, no re-request while the line stays high. A new rising edge → request again.
4. Level source 1 pending, in REQ. Write MASK=0 before ack → hw_int=0 one cycle later, state IDLE, active_id=7.
5. int_ack in IDLE and EOI in REQ → no state change. Reset (reset=0) asserted while in SERVICE → all registers zero, hw_int=0, active_id=7 after one edge.
6. IRQ_STAT_EN defined: 300 rising edges on edge-mode source 0 with CLEAR between them → counter at 0x20 reads 0xFF. Write 0x20 → reads 0.
